// File: rtl/pkg_cpu.sv
// pkg_cpu: core-side encodings shared with the memory access unit
package pkg_cpu;

    localparam logic cpu_data_acc_sz_8  = 1'b0;
    localparam logic cpu_data_acc_sz_16 = 1'b1;

endpackage

// File: rtl/pkg_mem_acc.sv
// pkg_mem_acc: states, access sizes, error causes and beat helpers for the memory access unit
package pkg_mem_acc;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} mem_acc_state;

    typedef enum logic [1:0] {SZ_8 = 2'd0, SZ_16 = 2'd1, SZ_32 = 2'd2} mem_acc_size;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_SIZE     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic logic [2:0] beat_count(input logic [1:0] size, input int bus_bytes);
        int bytes;
        bytes = 1 << size;
        return (bytes <= bus_bytes) ? 3'd1 : 3'(bytes / bus_bytes);
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        return (size == SZ_8) ? 32'h0000_00FF : (size == SZ_16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [1:0] err_cause(input logic [1:0] size, input logic addr_lsb);
        return (size == 2'd3) ? ERR_SIZE : (addr_lsb && size != SZ_8) ? ERR_MISALIGN : ERR_NONE;
    endfunction

    function automatic logic is_err(input logic [1:0] cause);
        return cause != ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_acc_wait_timer.sv
// mem_acc_wait_timer: counts consecutive stalled beat cycles and flags the last allowed one
module mem_acc_wait_timer #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_stall,
    output logic o_timeout
);

    logic [7:0] r_cnt;

    assign o_timeout = i_stall && r_cnt == 8'(WAIT_TIMEOUT - 1);

    // restart on every new beat or completed beat, count while the memory holds off
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= 8'd0;
        else
            r_cnt <= (i_clear || !i_stall) ? 8'd0 : r_cnt + 8'd1;
    end

endmodule

// File: rtl/spcpu_mem_access_unit.sv
// spcpu_mem_access_unit: splits big-endian core accesses into memory bus beats with wait/timeout handling
module spcpu_mem_access_unit
    import pkg_mem_acc::*;
    import pkg_cpu::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int BUS_BYTES    = 2,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic                    mem_acc_sz,
    output logic [8*BUS_BYTES-1:0]  mem_wdata,
    input  logic [8*BUS_BYTES-1:0]  mem_rdata,
    output logic                    mem_req,
    input  logic                    mem_ready
);

    localparam int BW = 8 * BUS_BYTES;

    mem_acc_state r_state;
    logic [2:0]   r_left;
    logic         r_we;
    logic [1:0]   r_size;
    logic [31:0]  r_wdata;
    logic [31:0]  r_rdata;
    logic [1:0]   w_cause;
    logic [4:0]   w_shift;
    logic [31:0]  w_wd;
    logic [31:0]  w_rnext;
    logic         w_stall;
    logic         w_timeout;

    assign req_ready = r_state == IDLE;
    assign w_stall   = r_state == BEAT && !mem_ready;
    assign w_cause   = err_cause(req_size, req_addr[0]);
    // write data is left-justified so the first beat always takes the top bus slice;
    // a byte on a wide bus sits in the lowest lane of that slice
    assign w_shift   = (req_size == SZ_32) ? 5'd0 : (req_size == SZ_16 || BUS_BYTES == 2) ? 5'd16 : 5'd24;
    assign w_wd      = (req_wdata & size_mask(req_size)) << w_shift;
    assign w_rnext   = 32'(r_rdata << BW) | 32'(mem_rdata);

    mem_acc_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (r_state != BEAT),
        .i_stall   (w_stall),
        .o_timeout (w_timeout)
    );

    // request FSM: accept in IDLE, run beats, pulse the response for one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_left     <= 3'd0;
            r_we       <= 1'b0;
            r_size     <= 2'd0;
            r_wdata    <= 32'd0;
            r_rdata    <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_acc_sz <= cpu_data_acc_sz_16;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_we    <= req_we;
                    r_size  <= req_size;
                    r_rdata <= 32'd0;
                    if (is_err(w_cause)) begin
                        r_state    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        r_state    <= BEAT;
                        r_left     <= beat_count(req_size, BUS_BYTES);
                        mem_req    <= 1'b1;
                        mem_we     <= req_we;
                        mem_addr   <= req_addr;
                        mem_wdata  <= w_wd[31 -: BW];
                        r_wdata    <= w_wd << BW;
                        mem_acc_sz <= (BUS_BYTES == 1 || req_size == SZ_8) ? cpu_data_acc_sz_8 : cpu_data_acc_sz_16;
                    end
                end
                BEAT: if (w_timeout) begin
                    r_state    <= RESP;
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= is_err(ERR_TIMEOUT);
                    resp_rdata <= 32'd0;
                end else if (mem_ready) begin
                    r_rdata <= w_rnext;
                    if (r_left == 3'd1) begin
                        r_state    <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_we ? 32'd0 : w_rnext & size_mask(r_size);
                    end else begin
                        r_left    <= r_left - 3'd1;
                        mem_addr  <= mem_addr + ADDR_WIDTH'(BUS_BYTES);
                        mem_wdata <= r_wdata[31 -: BW];
                        r_wdata   <= r_wdata << BW;
                    end
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spcpu_mem_access_unit.sv
// tb_spcpu_mem_access_unit: scoreboard bench for a 2-byte-bus and a 1-byte-bus instance
module tb_spcpu_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv0 = 1'b0, rv1 = 1'b0;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wdata = '0;

    logic        rdy0, vld0, err0, mwe0, msz0, mreq0;
    logic [31:0] rd0;
    logic [15:0] ma0, mwd0, mrd0;
    logic        rdy1, vld1, err1, mwe1, msz1, mreq1;
    logic [31:0] rd1;
    logic [15:0] ma1;
    logic [7:0]  mwd1, mrd1;
    logic        mrdy;

    logic [7:0]  m [65536];
    int          stall = 0;
    int          bw = 0;
    int          n_vec = 0, n_err = 0, n_req = 0, n_we = 0;
    logic        last_sz;
    logic [32:0] exp_q [$];
    logic [32:0] e_mon;
    logic [15:0] ba_q [$], wa_q [$], wd_q [$];

    always #5 clk = ~clk;

    assign mrdy = bw >= stall;
    assign mrd0 = (msz0 == 1'b0) ? {8'h00, m[ma0]} : {m[ma0], m[ma0 + 16'd1]};
    assign mrd1 = m[ma1];

    spcpu_mem_access_unit #(.ADDR_WIDTH(16), .BUS_BYTES(2), .WAIT_TIMEOUT(4)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_ready(rdy0), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(vld0),
        .resp_rdata(rd0), .resp_err(err0), .mem_addr(ma0), .mem_we(mwe0), .mem_acc_sz(msz0),
        .mem_wdata(mwd0), .mem_rdata(mrd0), .mem_req(mreq0), .mem_ready(mrdy)
    );

    spcpu_mem_access_unit #(.ADDR_WIDTH(16), .BUS_BYTES(1), .WAIT_TIMEOUT(4)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(vld1),
        .resp_rdata(rd1), .resp_err(err1), .mem_addr(ma1), .mem_we(mwe1), .mem_acc_sz(msz1),
        .mem_wdata(mwd1), .mem_rdata(mrd1), .mem_req(mreq1), .mem_ready(mrdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // memory stalls the first `stall` cycles of an access; the counter clears when no beat is active
    always @(posedge clk)
        bw <= (mreq0 || mreq1) ? (mrdy ? bw : bw + 1) : 0;

    // monitor: log beats and writes, count strobes, check responses against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (mreq0 && mrdy) begin
                ba_q.push_back(ma0);
                if (mwe0) begin wa_q.push_back(ma0); wd_q.push_back(mwd0); end
            end
            if (mreq1 && mrdy) begin
                ba_q.push_back(ma1);
                if (mwe1) begin wa_q.push_back(ma1); wd_q.push_back({8'h00, mwd1}); end
            end
            if (mreq0 || mreq1) n_req++;
            if (mwe0 || mwe1) n_we++;
            if (mreq0) last_sz = msz0;
            if (vld0 || vld1) begin
                if (exp_q.size() == 0)
                    chk("resp_unexpected", 32'd1, 32'd0);
                else begin
                    e_mon = exp_q.pop_front();
                    chk("resp_err", 32'(vld0 ? err0 : err1), 32'(e_mon[32]));
                    chk("resp_rdata", vld0 ? rd0 : rd1, e_mon[31:0]);
                end
            end
        end
    end

    task automatic issue(input bit s, input logic [15:0] a, input bit we, input logic [1:0] sz, input logic [31:0] wd);
        @(negedge clk);
        req_addr = a; req_we = we; req_size = sz; req_wdata = wd;
        if (s) rv1 = 1'b1; else rv0 = 1'b1;
        chk("req_ready", 32'(s ? rdy1 : rdy0), 32'd1);
        @(posedge clk);
        #1 rv0 = 1'b0; rv1 = 1'b0;
    endtask

    task automatic xact(input string tag, input bit s, input logic [15:0] a, input bit we, input logic [1:0] sz,
                        input logic [31:0] wd, input bit ee, input logic [31:0] er, input int lat,
                        output int nreq, output int nwe);
        int c, r0, w0;
        exp_q.push_back({ee, er});
        ba_q.delete(); wa_q.delete(); wd_q.delete();
        r0 = n_req; w0 = n_we; c = 0;
        issue(s, a, we, sz, wd);
        do begin @(negedge clk); c++; end while (!(s ? vld1 : vld0) && c < 40);
        chk({tag, "_latency"}, 32'(c), 32'(lat));
        nreq = n_req - r0; nwe = n_we - w0;
    endtask

    initial begin
        int nr, nw;
        m[16'h0010] = 8'h12; m[16'h0011] = 8'h34; m[16'h0012] = 8'h56; m[16'h0013] = 8'h78;
        m[16'h0031] = 8'hA5; m[16'h0030] = 8'h5A;
        m[16'hFFFE] = 8'hDE; m[16'hFFFF] = 8'hAD; m[16'h0000] = 8'hBE; m[16'h0001] = 8'hEF;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy0), 32'd1);
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_mem_req", 32'(mreq0), 32'd0);
        chk("rst_acc_sz", 32'(msz0), 32'd1);
        chk("rst_mem_addr", 32'(ma0), 32'd0);
        chk("rst_mem_wdata", 32'(mwd0), 32'd0);
        reset = 1'b0;

        xact("rd32", 0, 16'h0010, 0, 2'd2, 32'd0, 0, 32'h1234_5678, 3, nr, nw);
        chk("rd32_nbeats", 32'(ba_q.size()), 32'd2);
        chk("rd32_beat0", 32'(ba_q[0]), 32'h0010);
        chk("rd32_beat1", 32'(ba_q[1]), 32'h0012);
        chk("rd32_acc_sz", 32'(last_sz), 32'd1);

        xact("wr16_b1", 1, 16'h0020, 1, 2'd1, 32'h0000_BEEF, 0, 32'd0, 3, nr, nw);
        chk("wr16_we_cycles", 32'(nw), 32'd2);
        chk("wr16_nwrites", 32'(wa_q.size()), 32'd2);
        chk("wr16_addr0", 32'(wa_q[0]), 32'h0020);
        chk("wr16_data0", 32'(wd_q[0]), 32'h00BE);
        chk("wr16_addr1", 32'(wa_q[1]), 32'h0021);
        chk("wr16_data1", 32'(wd_q[1]), 32'h00EF);

        xact("rd8", 0, 16'h0031, 0, 2'd0, 32'd0, 0, 32'h0000_00A5, 2, nr, nw);
        chk("rd8_nbeats", 32'(nr), 32'd1);
        chk("rd8_acc_sz", 32'(last_sz), 32'd0);

        xact("misalign", 0, 16'h0033, 0, 2'd1, 32'd0, 1, 32'd0, 1, nr, nw);
        chk("misalign_mem_req", 32'(nr), 32'd0);

        xact("bad_size", 0, 16'h0040, 0, 2'd3, 32'd0, 1, 32'd0, 1, nr, nw);
        chk("bad_size_mem_req", 32'(nr), 32'd0);

        stall = 1000;
        xact("timeout", 0, 16'h0040, 0, 2'd1, 32'd0, 1, 32'd0, 5, nr, nw);
        chk("timeout_mem_req", 32'(nr), 32'd4);
        stall = 0;
        xact("after_to", 0, 16'h0010, 0, 2'd1, 32'd0, 0, 32'h0000_1234, 2, nr, nw);

        stall = 2;
        xact("wait2", 0, 16'h0010, 0, 2'd2, 32'd0, 0, 32'h1234_5678, 5, nr, nw);
        stall = 0;

        xact("wr32", 0, 16'h0050, 1, 2'd2, 32'hCAFE_F00D, 0, 32'd0, 3, nr, nw);
        chk("wr32_data0", 32'(wd_q[0]), 32'h0000_CAFE);
        chk("wr32_addr1", 32'(wa_q[1]), 32'h0052);
        chk("wr32_data1", 32'(wd_q[1]), 32'h0000_F00D);

        xact("wrap", 0, 16'hFFFE, 0, 2'd2, 32'd0, 0, 32'hDEAD_BEEF, 3, nr, nw);
        chk("wrap_beat0", 32'(ba_q[0]), 32'hFFFE);
        chk("wrap_beat1", 32'(ba_q[1]), 32'h0000);

        stall = 1000;
        issue(0, 16'h0010, 0, 2'd2, 32'd0);
        @(negedge clk); @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mreq0), 32'd0);
        chk("arst_ready", 32'(rdy0), 32'd1);
        chk("arst_acc_sz", 32'(msz0), 32'd1);
        chk("arst_mem_addr", 32'(ma0), 32'd0);
        chk("arst_valid", 32'(vld0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_no_resp", 32'(vld0), 32'd0);
        end
        xact("post_rst", 0, 16'h0012, 0, 2'd1, 32'd0, 0, 32'h0000_5678, 2, nr, nw);

        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
